// File: rtl/aurora_link_pkg.sv
// -----------------------------------------------------------------------------
// aurora_link_pkg
// Shared definitions for the Aurora link bring-up controller:
//   - link_state_t  : FSM state encoding (also exported on the STATE debug port)
//   - DEF_*         : default timing / retry parameter values
//   - RETRY_W       : width of the RETRY_CNT output
//   - PIDX_W        : width of the GT reset pulse index
//   - state_gt_reset / state_reset_pb : per-state drive of the core reset pins
// -----------------------------------------------------------------------------
package aurora_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GT_PULSE = 3'd1,
      ST_GT_GAP   = 3'd2,
      ST_SYS_HOLD = 3'd3,
      ST_WAIT_UP  = 3'd4,
      ST_STABLE   = 3'd5,
      ST_LINK_UP  = 3'd6,
      ST_FAIL     = 3'd7
   } link_state_t;

   localparam int DEF_PULSE_LEN     = 50;
   localparam int DEF_GAP_LEN       = 50;
   localparam int DEF_PULSE_COUNT   = 2;
   localparam int DEF_SYS_HOLD_LEN  = 64;
   localparam int DEF_LOCK_TIMEOUT  = 65535;
   localparam int DEF_STABLE_CYCLES = 1024;
   localparam int DEF_MAX_RETRIES   = 7;
   localparam int DEF_CNT_W         = 17;

   localparam int RETRY_W = 4;
   // Pulse index is kept wide enough for up to 255 pulses per attempt.
   localparam int PIDX_W  = 8;

   // GT_RESET is held high while idle, during a pulse and when parked in FAIL.
   function automatic logic state_gt_reset(input link_state_t s);
      return (s == ST_IDLE) || (s == ST_GT_PULSE) || (s == ST_FAIL);
   endfunction

   // RESET_PB is released only once the core is expected to come up.
   function automatic logic state_reset_pb(input link_state_t s);
      return !((s == ST_WAIT_UP) || (s == ST_STABLE) || (s == ST_LINK_UP));
   endfunction

endpackage

// File: rtl/aurora_link_if.sv
// -----------------------------------------------------------------------------
// aurora_link_if
// Signals between the link controller and one Aurora 8b/10b core.
//   GT_RESET   : controller -> core gt_reset
//   RESET_PB   : controller -> core reset_pb
//   LANE_UP    : core -> controller, lane up
//   CHANNEL_UP : core -> controller, channel up
//   HARD_ERR   : core -> controller, hard error (pulse or level)
// Signalling: there is no valid/ready transfer on this bundle. Every signal is
// a level sampled on each rising CLK edge; the reset outputs are registered and
// the status inputs are assumed synchronous to CLK.
// Modports: master = controller side, slave = core side.
// -----------------------------------------------------------------------------
interface aurora_link_if;
   logic GT_RESET;
   logic RESET_PB;
   logic LANE_UP;
   logic CHANNEL_UP;
   logic HARD_ERR;

   modport master (
      output GT_RESET,
      output RESET_PB,
      input  LANE_UP,
      input  CHANNEL_UP,
      input  HARD_ERR
   );

   modport slave (
      input  GT_RESET,
      input  RESET_PB,
      output LANE_UP,
      output CHANNEL_UP,
      output HARD_ERR
   );
endinterface

// File: rtl/link_timer.sv
// -----------------------------------------------------------------------------
// link_timer
// Free-running CNT_W-bit up-counter with synchronous clear. done is high while
// the count equals target-1, so a clear on the edge entering a state followed
// by a transition on done gives a state exactly 'target' cycles long.
//   CLK     : clock, rising edge
//   RESET_N : asynchronous active-low reset (count -> 0)
//   clear   : synchronous clear, count is 0 in the following cycle
//   target  : runtime length in cycles (>= 1 when done is used)
//   done    : count == target-1
// -----------------------------------------------------------------------------
module link_timer #(
   parameter int CNT_W = 17
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             clear,
   input  logic [CNT_W-1:0] target,
   output logic             done
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign done = (count_q == (target - CNT_W'(1)));

endmodule

// File: rtl/aurora_link_ctrl.sv
// -----------------------------------------------------------------------------
// aurora_link_ctrl
// Bring-up and supervision controller for one Aurora 8b/10b SFP link. Runs the
// GT reset pulse train, holds reset_pb, waits for LANE_UP/CHANNEL_UP, qualifies
// the link as stable, then supervises it and restarts on loss, timeout or hard
// error with a bounded number of retries.
// Ports:
//   CLK, RESET_N   : clock (rising edge), asynchronous active-low reset
//   ENABLE         : bring-up enable (level)
//   PLL_LOCK       : GT reference PLL lock, synchronous to CLK
//   FORCE_RESTART  : single-cycle restart request
//   aur (master)   : GT_RESET/RESET_PB out, LANE_UP/CHANNEL_UP/HARD_ERR in
//   LINK_OK        : link qualified and up
//   LINK_FAIL      : retries exhausted
//   RETRY_CNT      : failed attempts in the current bring-up
//   STATE          : FSM state encoding (debug)
// All outputs are registered and change on the edge that enters a state.
// -----------------------------------------------------------------------------
module aurora_link_ctrl
   import aurora_link_pkg::*;
#(
   parameter int PULSE_LEN     = DEF_PULSE_LEN,
   parameter int GAP_LEN       = DEF_GAP_LEN,
   parameter int PULSE_COUNT   = DEF_PULSE_COUNT,
   parameter int SYS_HOLD_LEN  = DEF_SYS_HOLD_LEN,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               ENABLE,
   input  logic               PLL_LOCK,
   input  logic               FORCE_RESTART,
   aurora_link_if.master      aur,
   output logic               LINK_OK,
   output logic               LINK_FAIL,
   output logic [RETRY_W-1:0] RETRY_CNT,
   output logic [2:0]         STATE
);

   link_state_t        state_q, state_d;
   logic [PIDX_W-1:0]  pidx_q, pidx_d, pidx_inc;
   logic [RETRY_W-1:0] retry_d, retry_inc;
   logic [CNT_W-1:0]   tmr_target;
   logic               tmr_done;
   logic               enter;
   logic               do_retry;
   logic               links_up;

   assign links_up = aur.LANE_UP & aur.CHANNEL_UP;
   assign STATE    = state_q;

   // Saturating increment; RETRY_CNT never wraps back to zero.
   assign retry_inc = (RETRY_CNT == '1) ? RETRY_CNT : (RETRY_CNT + RETRY_W'(1));
   assign pidx_inc  = pidx_q + PIDX_W'(1);

   // Length of the current state; states without a fixed length ignore done.
   always_comb begin
      tmr_target = '0;
      case (state_q)
         ST_GT_PULSE: tmr_target = CNT_W'(PULSE_LEN);
         ST_GT_GAP:   tmr_target = CNT_W'(GAP_LEN);
         ST_SYS_HOLD: tmr_target = CNT_W'(SYS_HOLD_LEN);
         ST_WAIT_UP:  tmr_target = CNT_W'(LOCK_TIMEOUT);
         ST_STABLE:   tmr_target = CNT_W'(STABLE_CYCLES);
         default:     tmr_target = '0;
      endcase
   end

   // Transition function. 'enter' marks every state entry (including a
   // restart back into GT_PULSE) so the timer is cleared on that same edge.
   always_comb begin
      state_d  = state_q;
      retry_d  = RETRY_CNT;
      pidx_d   = pidx_q;
      enter    = 1'b0;
      do_retry = 1'b0;

      if (!ENABLE) begin
         state_d = ST_IDLE;
         retry_d = '0;
         pidx_d  = '0;
         enter   = 1'b1;
      end else if (!PLL_LOCK) begin
         // Lock loss keeps the retry history of the current bring-up.
         state_d = ST_IDLE;
         pidx_d  = '0;
         enter   = 1'b1;
      end else if (FORCE_RESTART && (state_q != ST_IDLE)) begin
         state_d = ST_GT_PULSE;
         retry_d = '0;
         pidx_d  = '0;
         enter   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ENABLE && PLL_LOCK) begin
                  state_d = ST_GT_PULSE;
                  pidx_d  = '0;
                  enter   = 1'b1;
               end
            end
            ST_GT_PULSE: begin
               if (tmr_done) begin
                  state_d = ST_GT_GAP;
                  enter   = 1'b1;
               end
            end
            ST_GT_GAP: begin
               if (tmr_done) begin
                  pidx_d  = pidx_inc;
                  state_d = (int'(pidx_inc) < PULSE_COUNT) ? ST_GT_PULSE : ST_SYS_HOLD;
                  enter   = 1'b1;
               end
            end
            ST_SYS_HOLD: begin
               if (tmr_done) begin
                  state_d = ST_WAIT_UP;
                  enter   = 1'b1;
               end
            end
            ST_WAIT_UP: begin
               // Link coming up on the last allowed cycle still wins over timeout.
               if (aur.HARD_ERR) begin
                  do_retry = 1'b1;
               end else if (links_up) begin
                  state_d = ST_STABLE;
                  enter   = 1'b1;
               end else if (tmr_done) begin
                  do_retry = 1'b1;
               end
            end
            ST_STABLE: begin
               if (aur.HARD_ERR || !links_up) begin
                  do_retry = 1'b1;
               end else if (tmr_done) begin
                  state_d = ST_LINK_UP;
                  retry_d = '0;
                  enter   = 1'b1;
               end
            end
            ST_LINK_UP: begin
               // Losing an established link starts a fresh attempt, not a retry.
               if (!links_up || aur.HARD_ERR) begin
                  state_d = ST_GT_PULSE;
                  retry_d = '0;
                  pidx_d  = '0;
                  enter   = 1'b1;
               end
            end
            ST_FAIL: begin
               // Parked until ENABLE drops or FORCE_RESTART (handled above).
            end
            default: begin
               state_d = ST_IDLE;
               enter   = 1'b1;
            end
         endcase

         if (do_retry) begin
            retry_d = retry_inc;
            pidx_d  = '0;
            state_d = (int'(retry_inc) == MAX_RETRIES) ? ST_FAIL : ST_GT_PULSE;
            enter   = 1'b1;
         end
      end
   end

   // State register with outputs decoded from the next state, so each state's
   // outputs appear on the same edge that enters it.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= ST_IDLE;
         pidx_q       <= '0;
         RETRY_CNT    <= '0;
         aur.GT_RESET <= 1'b1;
         aur.RESET_PB <= 1'b1;
         LINK_OK      <= 1'b0;
         LINK_FAIL    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pidx_q       <= pidx_d;
         RETRY_CNT    <= retry_d;
         aur.GT_RESET <= state_gt_reset(state_d);
         aur.RESET_PB <= state_reset_pb(state_d);
         LINK_OK      <= (state_d == ST_LINK_UP);
         LINK_FAIL    <= (state_d == ST_FAIL);
      end
   end

   link_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .clear   (enter),
      .target  (tmr_target),
      .done    (tmr_done)
   );

endmodule

// File: tb/tb_aurora_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aurora_link_ctrl
// Directed bench for aurora_link_ctrl. The stimulus pushes the expected output
// changes (with the number of cycles since the previous change) into exp_q;
// the monitor watches the output vector and pops/compares on every change.
// -----------------------------------------------------------------------------
module tb_aurora_link_ctrl;

   localparam int W = 27;   // {dur[15:0], state[2:0], gt, pb, ok, fail, rc[3:0]}

   logic       CLK           = 1'b0;
   logic       RESET_N       = 1'b1;
   logic       ENABLE        = 1'b0;
   logic       PLL_LOCK      = 1'b0;
   logic       FORCE_RESTART = 1'b0;
   logic       LINK_OK;
   logic       LINK_FAIL;
   logic [3:0] RETRY_CNT;
   logic [2:0] STATE;

   aurora_link_if aur();

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [W-1:0] exp_q[$];

   aurora_link_ctrl #(
      .PULSE_LEN     (4),
      .GAP_LEN       (4),
      .PULSE_COUNT   (2),
      .SYS_HOLD_LEN  (8),
      .LOCK_TIMEOUT  (32),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (3),
      .CNT_W         (17)
   ) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .ENABLE        (ENABLE),
      .PLL_LOCK      (PLL_LOCK),
      .FORCE_RESTART (FORCE_RESTART),
      .aur           (aur),
      .LINK_OK       (LINK_OK),
      .LINK_FAIL     (LINK_FAIL),
      .RETRY_CNT     (RETRY_CNT),
      .STATE         (STATE)
   );

   // ---------------- clock / cycle count ----------------
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of test after 200000 time units, required finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- expected-value helpers ----------------
   // Per-state reset-pin levels and flags taken from the state table.
   function automatic logic [10:0] outs_of(input logic [2:0] st, input logic [3:0] rc);
      logic gt, pb, ok, fl;
      gt = (st == 3'd0) || (st == 3'd1) || (st == 3'd7);
      pb = (st <= 3'd3) || (st == 3'd7);
      ok = (st == 3'd6);
      fl = (st == 3'd7);
      return {st, gt, pb, ok, fl, rc};
   endfunction

   // dur = 0 means the interval before this change is not checked.
   task automatic push(input int dur, input logic [2:0] st, input logic [3:0] rc);
      exp_q.push_back({16'(dur), outs_of(st, rc)});
   endtask

   // One full reset train: pulse, gap, pulse, gap, sys hold, then WAIT_UP.
   task automatic push_train(input int first_dur, input logic [3:0] rc);
      push(first_dur, 3'd1, rc);
      push(4, 3'd2, rc);
      push(4, 3'd1, rc);
      push(4, 3'd2, rc);
      push(4, 3'd3, rc);
      push(8, 3'd4, rc);
   endtask

   task automatic set_links(input logic v);
      aur.LANE_UP    = v;
      aur.CHANNEL_UP = v;
   endtask

   // Waits (sampling on falling edges) until STATE == st, bounded by budget.
   task automatic wait_state(input logic [2:0] st, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while ((STATE != st) && (n < budget));
      if (STATE != st) begin
         total++;
         bad++;
         $display("FAIL wait_state: got state=%0d after %0d cycles, required state=%0d", STATE, n, st);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic [10:0]  cur;
      logic [10:0]  prev;
      logic [W-1:0] e;
      logic [15:0]  dur;
      logic         seen;
      int           last_cyc;
      seen     = 1'b0;
      prev     = '0;
      last_cyc = 0;
      forever begin
         @(negedge CLK or negedge RESET_N);
         #1;
         cur = {STATE, aur.GT_RESET, aur.RESET_PB, LINK_OK, LINK_FAIL, RETRY_CNT};
         if (!seen || (cur != prev)) begin
            dur = 16'(cyc - last_cyc);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change: got state=%0d gt=%b pb=%b ok=%b fail=%b rc=%0d after %0d cycles, required no change",
                        cur[10:8], cur[7], cur[6], cur[5], cur[4], cur[3:0], dur);
            end else begin
               e = exp_q.pop_front();
               if ((e[10:0] != cur) || ((e[26:11] != 16'd0) && (e[26:11] != dur))) begin
                  bad++;
                  $display("FAIL out_seq: got state=%0d gt=%b pb=%b ok=%b fail=%b rc=%0d after %0d cycles, required state=%0d gt=%b pb=%b ok=%b fail=%b rc=%0d after %0d cycles",
                           cur[10:8], cur[7], cur[6], cur[5], cur[4], cur[3:0], dur,
                           e[10:8], e[7], e[6], e[5], e[4], e[3:0], e[26:11]);
               end
            end
            prev     = cur;
            seen     = 1'b1;
            last_cyc = cyc;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : driver
      set_links(1'b0);
      aur.HARD_ERR = 1'b0;

      // Reset values.
      push(0, 3'd0, 4'd0);
      #1 RESET_N = 1'b0;
      ENABLE   = 1'b1;
      PLL_LOCK = 1'b1;

      // Nominal bring-up: links rise 5 cycles into WAIT_UP.
      push_train(0, 4'd0);
      push(6, 3'd5, 4'd0);
      push(8, 3'd6, 4'd0);
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      wait_state(3'd4, 100);
      repeat (5) @(negedge CLK);
      set_links(1'b1);
      wait_state(3'd6, 100);

      // Link loss by HARD_ERR, then a stability glitch at STABLE cycle 5.
      push_train(4, 4'd0);
      push(3, 3'd5, 4'd0);
      push_train(6, 4'd1);
      push(1, 3'd5, 4'd1);
      push(8, 3'd6, 4'd0);
      repeat (3) @(negedge CLK);
      aur.HARD_ERR = 1'b1;
      @(negedge CLK);
      aur.HARD_ERR = 1'b0;
      set_links(1'b0);
      wait_state(3'd4, 100);
      repeat (2) @(negedge CLK);
      set_links(1'b1);
      wait_state(3'd5, 100);
      repeat (5) @(negedge CLK);
      aur.CHANNEL_UP = 1'b0;
      @(negedge CLK);
      aur.CHANNEL_UP = 1'b1;
      wait_state(3'd6, 200);

      // Loss of link, then three WAIT_UP timeouts into FAIL.
      push_train(3, 4'd0);
      push_train(32, 4'd1);
      push_train(32, 4'd2);
      push(32, 3'd7, 4'd3);
      repeat (2) @(negedge CLK);
      set_links(1'b0);
      wait_state(3'd7, 400);

      // FORCE_RESTART out of FAIL, then lock loss beats restart in GT_GAP,
      // then a second run to FAIL.
      push(3, 3'd1, 4'd0);
      push(4, 3'd2, 4'd0);
      push(2, 3'd0, 4'd0);
      push_train(2, 4'd0);
      push_train(32, 4'd1);
      push_train(32, 4'd2);
      push(32, 3'd7, 4'd3);
      repeat (2) @(negedge CLK);
      FORCE_RESTART = 1'b1;
      @(negedge CLK);
      FORCE_RESTART = 1'b0;
      wait_state(3'd2, 50);
      @(negedge CLK);
      FORCE_RESTART = 1'b1;
      PLL_LOCK      = 1'b0;
      @(negedge CLK);
      FORCE_RESTART = 1'b0;
      @(negedge CLK);
      PLL_LOCK = 1'b1;
      wait_state(3'd7, 400);

      // ENABLE low in FAIL clears everything; re-enable and reach STABLE.
      push(2, 3'd0, 4'd0);
      push_train(3, 4'd0);
      push(1, 3'd5, 4'd0);
      // Asynchronous reset 3 cycles into STABLE, between clock edges.
      push(3, 3'd0, 4'd0);
      @(negedge CLK);
      ENABLE = 1'b0;
      repeat (3) @(negedge CLK);
      ENABLE = 1'b1;
      set_links(1'b1);
      wait_state(3'd5, 100);
      repeat (3) @(posedge CLK);
      #2 RESET_N = 1'b0;
      repeat (3) @(negedge CLK);
      #2;

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover: got %0d expected changes never seen, required 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
